// File: rtl/pattern_seq_arb.sv
// Two-requester round-robin front end for a shared fixed-latency pattern block.
// One transaction is in flight at a time: accept, wait LAT cycles, capture, then a response handshake.
module pattern_seq_arb #(
  parameter int VEC_W = 11,
  parameter int RES_W = 8,
  parameter int LAT   = 2
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             req0_valid,
  input  logic [VEC_W-1:0] req0_vec,
  input  logic             req1_valid,
  input  logic [VEC_W-1:0] req1_vec,
  output logic             req0_ready,
  output logic             req1_ready,
  output logic [VEC_W-1:0] pat_in,
  input  logic [RES_W-1:0] pat_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [RES_W-1:0] rsp_data,
  output logic             busy,
  output logic [15:0]      done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LAT_L = 4'(LAT);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant0;
  logic       grant1;
  logic       accept;
  logic       capture;
  logic       complete;

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) state <= IDLE;
    else                 state <= state_nx;
  end

  // last_grant == 1 means requester 1 won most recently, so requester 0 wins the next tie.
  always_comb begin
    grant0   = 1'b0;
    grant1   = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    state_nx = state;
    unique case (state)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
        if (grant0 | grant1) state_nx = WAIT;
      end
      WAIT: begin
        capture = (cnt == 4'd1);
        if (capture) state_nx = RESP;
      end
      RESP: begin
        complete = rsp_ready;
        if (complete) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept     = grant0 | grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      pat_in     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      done_cnt   <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      pat_in     <= grant1 ? req1_vec : req0_vec;
      rsp_id     <= grant1;
      last_grant <= grant1;
      cnt        <= LAT_L;
    end else if (state == WAIT) begin
      cnt <= cnt - 4'd1;
      if (capture) begin
        rsp_data  <= pat_out;
        rsp_valid <= 1'b1;
      end
    end else if (complete) begin
      rsp_valid <= 1'b0;
      done_cnt  <= done_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pattern_seq_arb.md
PATTERN_SEQ_ARB -- requirements
Module: pattern_seq_arb

Interface
REQ-001 SHALL have parameter VEC_W, default 11: width of the stimulus vector applied to the shared pattern block.
REQ-002 SHALL have parameter RES_W, default 8: width of the pattern block result.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..15: pattern block input-to-output latency in cycles.
REQ-004 SHALL have port blif_clk_net  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port blif_reset_net  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have ports req0_valid / req1_valid  in  1  requester has a vector pending.
REQ-007 SHALL have ports req0_vec / req1_vec  in  VEC_W  requester stimulus vector.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  grant/accept strobe per requester.
REQ-009 SHALL have port pat_in  out  VEC_W  registered drive to the shared pattern block inputs.
REQ-010 SHALL have port pat_out  in  RES_W  pattern block outputs.
REQ-011 SHALL have ports rsp_valid  out  1 and rsp_ready  in  1: result handshake.
REQ-012 SHALL have ports rsp_id  out  1 (requester index) and rsp_data  out  RES_W (captured result).
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port done_cnt  out  16  count of completed transactions.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one transaction in flight at most.
REQ-016 SHALL, in IDLE, assert exactly one reqN_ready (combinational) toward the granted valid requester; both readys are 0 outside IDLE or when no valid.
REQ-017 SHALL arbitrate round-robin: single valid wins; both valid -> requester not granted last; last-grant register resets to 1, so req0 wins first contention.
REQ-018 SHALL, on accept (valid & ready in IDLE), load pat_in with the granted vector, record the id, load the latency counter with LAT, enter WAIT.
REQ-019 SHALL hold pat_in stable from accept until the next accept; pat_in is never changed in WAIT or RESP.
REQ-020 SHALL decrement the counter each WAIT cycle; at the edge where it reaches 0 (LAT edges after pat_in updated) capture pat_out into rsp_data, set rsp_valid, enter RESP.
REQ-021 SHALL hold rsp_valid, rsp_id and rsp_data stable in RESP until rsp_ready is sampled high; then clear rsp_valid, increment done_cnt, return to IDLE.
REQ-022 SHALL give minimum throughput of one transaction per LAT+2 cycles; no new accept in the cycle RESP completes (IDLE re-entered first).
REQ-023 SHALL ignore reqN_valid changes and rsp_ready outside their owning states; rsp_ready high in IDLE/WAIT has no effect.
REQ-024 SHALL wrap done_cnt from 16'hFFFF to 16'h0000 without any flag.
REQ-025 SHALL not update the last-grant register when only one requester is valid except to record that grant.

Reset
REQ-026 SHALL, on blif_reset_net low, immediately force IDLE, pat_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, done_cnt=0, counter=0, last-grant=1, busy=0.
REQ-027 SHALL discard any in-flight transaction on reset mid-operation; no response is produced for it after release.
REQ-028 SHALL resume arbitration on the first rising edge after blif_reset_net returns high.

Verification
REQ-029 Single request: req0_valid=1, req0_vec=11'h5A3, LAT=2, rsp_ready=1 -> req0_ready pulses 1 cycle, pat_in=11'h5A3 next cycle, rsp_valid 2 cycles later with rsp_id=0, rsp_data=pat_out then, done_cnt=1.
REQ-030 Contention: both valid continuously for 4 transactions -> grants 0,1,0,1; rsp_id sequence identical.
REQ-031 Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_data/pat_in stable, no readys asserted, completion on the cycle rsp_ready=1.
REQ-032 Reset mid-WAIT: drop blif_reset_net during WAIT -> all outputs per REQ-026 asynchronously, no rsp_valid after release, next req0 accepted.
REQ-033 Counter wrap: preload scenario driving 65536 transactions (or forced state) -> done_cnt 16'hFFFF -> 16'h0000.
REQ-034 LAT=1 and LAT=15 builds: capture occurs exactly LAT edges after pat_in update.
